// File: rtl/qsg_pkg.sv
// Shared types and constants for the quadrature step generator: FSM state
// encoding, {a,b} line codes, direction encoding and the per-state line code.
package qsg_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PH1  = 3'd1,
      S_PH2  = 3'd2,
      S_PH3  = 3'd3,
      S_GAP  = 3'd4
   } qsg_state_e;

   // {a,b} codes; both lines idle high.
   localparam logic [1:0] AB_REST  = 2'b11;
   localparam logic [1:0] AB_BOTH0 = 2'b00;
   localparam logic [1:0] AB_A0    = 2'b01;
   localparam logic [1:0] AB_B0    = 2'b10;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;

   // Right steps pull A low first (A leads), left steps pull B low first.
   function automatic logic [1:0] qsg_ab(input qsg_state_e st, input logic dir);
      logic [1:0] code;
      case (st)
         S_PH1:   code = (dir == DIR_RIGHT) ? AB_A0 : AB_B0;
         S_PH2:   code = AB_BOTH0;
         S_PH3:   code = (dir == DIR_RIGHT) ? AB_B0 : AB_A0;
         default: code = AB_REST;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/qsg_fifo.sv
// Small 1-bit-wide FIFO holding queued step directions.
// Pushes while full and pops while empty are dropped.
module qsg_fifo
   import qsg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_din,
   input  logic                     i_pop,
   output logic                     o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("qsg_fifo: DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   logic          r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW + 1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is not reset; the flushed pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

endmodule

// File: rtl/quad_step_gen.sv
// Queued quadrature step generator: each step walks {a,b} through three
// phases and a rest gap. Optional contact-bounce emulation: QSG_BOUNCE_EN.
module quad_step_gen
   import qsg_pkg::*;
#(
   parameter int PHASE_CYC = 1000,
   parameter int GAP_CYC   = 4000,
   parameter int QDEPTH    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic step_valid,
   input  logic step_dir,
   output logic step_ready,
   output logic a,
   output logic b,
   output logic busy,
   output logic done
);

   localparam int MAXC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] PH_LOAD  = CW'(PHASE_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

   generate
      if (PHASE_CYC < 1 || GAP_CYC < 1) begin : g_bad_cyc
         $error("quad_step_gen: PHASE_CYC and GAP_CYC must be at least 1");
      end
`ifdef QSG_BOUNCE_EN
      if (PHASE_CYC < 4 || GAP_CYC < 4) begin : g_bad_bounce
         $error("quad_step_gen: bounce needs PHASE_CYC >= 4 and GAP_CYC >= 4");
      end
`endif
   endgenerate

   qsg_state_e              r_state;
   qsg_state_e              w_nxt_state;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_load;
   logic                    w_cnt_zero;
   logic                    w_enter;
   logic                    r_dir;
   logic                    w_nxt_dir;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_head;
   logic                    w_full;
   logic                    w_empty;
   logic [$clog2(QDEPTH):0] w_count;
   logic [1:0]              w_ab_new;
   logic [1:0]              w_ab_out;
   logic [1:0]              r_ab;
   logic                    r_done;

   assign w_push = step_valid && step_ready;

   qsg_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (step_dir),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_pop       = 1'b0;
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_nxt_state = S_PH1;
            end
         end
         S_PH1: if (w_cnt_zero) w_nxt_state = S_PH2;
         S_PH2: if (w_cnt_zero) w_nxt_state = S_PH3;
         S_PH3: if (w_cnt_zero) w_nxt_state = S_GAP;
         S_GAP: begin
            if (w_cnt_zero) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_nxt_state = S_PH1;
               end else begin
                  w_nxt_state = S_IDLE;
               end
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   assign w_enter   = (w_nxt_state != r_state);
   assign w_nxt_dir = w_pop ? w_head : r_dir;
   assign w_ab_new  = qsg_ab(w_nxt_state, w_nxt_dir);

   always_comb begin
      w_load = PH_LOAD;
      if (w_nxt_state == S_GAP)       w_load = GAP_LOAD;
      else if (w_nxt_state == S_IDLE) w_load = '0;
   end

`ifdef QSG_BOUNCE_EN
   logic [1:0]    r_ab_nom;
   logic [1:0]    r_ab_old;
   logic [CW-1:0] w_cur_load;

   assign w_cur_load = (r_state == S_GAP) ? GAP_LOAD : PH_LOAD;

   // Second cycle of every active state shows the previous code again.
   always_comb begin
      w_ab_out = r_ab_nom;
      if (w_enter)
         w_ab_out = w_ab_new;
      else if (r_state != S_IDLE && r_cnt == w_cur_load)
         w_ab_out = r_ab_old;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ab_nom <= AB_REST;
         r_ab_old <= AB_REST;
      end else begin
         r_ab_nom <= w_ab_new;
         if (w_enter) r_ab_old <= r_ab_nom;
      end
   end
`else
   assign w_ab_out = w_ab_new;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dir   <= DIR_LEFT;
         r_ab    <= AB_REST;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (w_pop) r_dir <= w_head;
         if (w_enter)
            r_cnt <= w_load;
         else if (!w_cnt_zero)
            r_cnt <= r_cnt - 1'b1;
         r_ab   <= w_ab_out;
         r_done <= (w_nxt_state == S_GAP) && (r_state != S_GAP);
      end
   end

   assign a          = r_ab[1];
   assign b          = r_ab[0];
   assign done       = r_done;
   assign step_ready = !w_full;
   assign busy       = (r_state != S_IDLE) || (w_count != '0);

endmodule
